// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit counter width: enough bits to count NDIG digits, never less than 1.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple-borrow subtractor: d = a - b - bin.
// bmsb_in exposes the borrow entering the top bit so the caller can form
// the signed-overflow flag when this is the most significant digit.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout,
  output logic             bmsb_in
);

  logic [DIGIT:0] br;

  assign br[0] = bin;

  // One full-subtract cell per bit; borrow ripples from LSB to MSB.
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]    = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bout    = br[DIGIT];
  assign bmsb_in = br[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = minuend - subtrahend - borrow_in,
// DIGIT bits per clock, registered borrow between digits.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit per cycle, LSB digit first
// DONE  | result held, out_valid high until out_ready
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: illegal WIDTH/DIGIT combination");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             ov_q, ov_d;

  logic [DIGIT-1:0]       dig_d;
  logic                   dig_bout;
  logic                   dig_bmsb;
  logic [WIDTH+DIGIT-1:0] d_shift;

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .a       (a_q[DIGIT-1:0]),
    .b       (b_q[DIGIT-1:0]),
    .bin     (br_q),
    .d       (dig_d),
    .bout    (dig_bout),
    .bmsb_in (dig_bmsb)
  );

  // New digit enters at the top; the whole diff register moves down by DIGIT.
  assign d_shift = {dig_d, d_q};

  // Next-state, counter and datapath decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    br_d    = br_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = minuend;
          b_d     = subtrahend;
          br_d    = borrow_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        d_d   = d_shift[WIDTH+DIGIT-1:DIGIT];
        br_d  = dig_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Flags are captured only from the MSB digit so they stay put in DONE/IDLE.
          bo_d    = dig_bout;
          ov_d    = dig_bout ^ dig_bmsb;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = d_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;

endmodule
